instr_fetch_mem: RTL and testbench

Parametrised instruction memory for the MIPS32 DSP pipeline, sitting between the PC/fetch stage and IF/ID. It supports configurable word width and depth, and converts byte addresses to word indices. It provides a synchronous one-cycle read with a valid/ready fetch handshake and output stall. It also provides a runtime program-load port, a post-reset clear sweep that fills memory with NOPs, alignment and range fault reporting, and a branch flush.

---
 rtl/instr_fetch_mem.sv | 123 ++++++++++++
 tb/tb_instr_fetch_mem.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_mem.sv
// Instruction memory for the fetch stage: clears itself to NOPs after reset,
// then serves one-cycle registered fetches with a valid/ready handshake,
// accepts program loads and reports misaligned/out-of-range fetch addresses.
module instr_fetch_mem #(
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        DEPTH     = 256,
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [DATA_W-1:0]  INIT_WORD = '0,
    localparam int unsigned       OFFS      = $clog2(DATA_W / 8),
    localparam int unsigned       IDX_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [1:0]        rsp_fault,
    input  logic              flush,
    input  logic              ld_en,
    output logic              ld_ready,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic [DATA_W-1:0] ld_data,
    output logic              init_done
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST    = IDX_W'(DEPTH - 1);

    state_t              state, state_n;
    logic [IDX_W-1:0]    cnt, cnt_n;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                we;
    logic [IDX_W-1:0]    wa;
    logic [DATA_W-1:0]   wd;

    logic [ADDR_W-1:0]   word_addr;
    logic                misal;
    logic                oor;
    logic                accept;

    // Sweep state and counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: walk every word once, then stay in RUN until reset
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == CLEAR) begin
            if (cnt == LAST) begin
                state_n = RUN;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

    // Address decode, handshake and status outputs
    always_comb begin
        word_addr = req_addr >> OFFS;
        misal     = (req_addr[OFFS-1:0] != '0);
        oor       = (word_addr >= DEPTH_A);
        req_ready = (state == RUN) && !ld_en && !flush && (!rsp_valid || rsp_ready);
        accept    = req_valid && req_ready;
        ld_ready  = (state == RUN);
        init_done = (state == RUN);
    end

    // Single write port shared by the clear sweep and the program loader
    always_comb begin
        we = 1'b0;
        wa = cnt;
        wd = INIT_WORD;
        if (state == CLEAR) begin
            we = 1'b1;
        end else if (ld_en && (32'(ld_idx) < DEPTH)) begin
            we = 1'b1;
            wa = ld_idx;
            wd = ld_data;
        end
    end

    // Instruction storage, no reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    // Response register: load on accept, hold under back-pressure, drop on flush/take
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_instr <= '0;
            rsp_addr  <= '0;
            rsp_fault <= '0;
        end else if (flush) begin
            rsp_valid <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_addr  <= req_addr;
            rsp_fault <= {oor, misal};
            rsp_instr <= (misal || oor) ? INIT_WORD : mem[word_addr[IDX_W-1:0]];
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Randomised bench for instr_fetch_mem against a behavioural memory/response model.
module tb_instr_fetch_mem;

    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic [1:0]  rsp_fault;
    logic        flush = 1'b0;
    logic        ld_en = 1'b0;
    logic        ld_ready;
    logic [7:0]  ld_idx = '0;
    logic [31:0] ld_data = '0;
    logic        init_done;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Model state
    bit          m_run;
    int unsigned m_cycles;
    logic [31:0] m_mem [DEPTH];
    bit          m_rv;
    logic [31:0] m_ri;
    logic [31:0] m_ra;
    logic [1:0]  m_rf;

    always #5 clk = ~clk;

    instr_fetch_mem #(
        .DATA_W    (32),
        .DEPTH     (DEPTH),
        .ADDR_W    (32),
        .INIT_WORD (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_fault (rsp_fault),
        .flush     (flush),
        .ld_en     (ld_en),
        .ld_ready  (ld_ready),
        .ld_idx    (ld_idx),
        .ld_data   (ld_data),
        .init_done (init_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        return m_run && !ld_en && !flush && (!m_rv || rsp_ready);
    endfunction

    task automatic model_reset();
        m_run    = 1'b0;
        m_cycles = 0;
        m_rv     = 1'b0;
        m_ri     = '0;
        m_ra     = '0;
        m_rf     = '0;
    endtask

    task automatic check_outputs();
        check("req_ready", req_ready, exp_ready());
        check("ld_ready",  ld_ready,  m_run);
        check("init_done", init_done, m_run);
        check("rsp_valid", rsp_valid, m_rv);
        if (m_rv) begin
            check("rsp_instr", rsp_instr, m_ri);
            check("rsp_addr",  rsp_addr,  m_ra);
            check("rsp_fault", rsp_fault, m_rf);
        end
    endtask

    // Apply one clock edge to the model using the currently driven inputs
    task automatic model_edge(output bit acc);
        int unsigned widx;
        bit mis, oor;
        acc = exp_ready() && req_valid;
        if (!m_run) begin
            m_cycles++;
            if (m_cycles == DEPTH) begin
                m_run = 1'b1;
                foreach (m_mem[i]) m_mem[i] = 32'h0000_0000;
            end
        end else if (ld_en && (int'(ld_idx) < DEPTH)) begin
            m_mem[ld_idx] = ld_data;
        end
        if (flush) begin
            m_rv = 1'b0;
        end else if (acc) begin
            widx = req_addr / 4;
            mis  = (req_addr % 4) != 0;
            oor  = widx >= DEPTH;
            m_rv = 1'b1;
            m_ra = req_addr;
            m_rf = {oor, mis};
            m_ri = (mis || oor) ? 32'h0000_0000 : m_mem[widx];
        end else if (rsp_ready) begin
            m_rv = 1'b0;
        end
    endtask

    task automatic cyc(input bit v, input logic [31:0] a, input bit rr, input bit fl,
                       input bit le, input logic [7:0] li, input logic [31:0] ld,
                       output bit acc);
        @(negedge clk);
        req_valid = v;
        req_addr  = a;
        rsp_ready = rr;
        flush     = fl;
        ld_en     = le;
        ld_idx    = li;
        ld_data   = ld;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge(acc);
    endtask

    task automatic fetch(input logic [31:0] a, input bit rr);
        bit acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            cyc(1'b1, a, rr, 1'b0, 1'b0, 8'd0, 32'd0, acc);
        end
        check("fetch_accept", acc, 1'b1);
    endtask

    task automatic load(input logic [7:0] li, input logic [31:0] ld);
        bit acc;
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, li, ld, acc);
    endtask

    task automatic idle(input bit rr);
        bit acc;
        cyc(1'b0, 32'd0, rr, 1'b0, 1'b0, 8'd0, 32'd0, acc);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned sel = $urandom_range(0, 9);
        int unsigned idx = $urandom_range(0, 15);
        if (sel <= 6) return 32'(idx * 4);
        if (sel == 7) return 32'(idx * 4 + $urandom_range(1, 3));
        if (sel == 8) return 32'h400 + 32'($urandom_range(0, 255));
        return 32'($urandom);
    endfunction

    task automatic rand_cycle();
        bit acc;
        cyc($urandom_range(0, 99) < 70, rand_addr(), $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 20,
            8'($urandom_range(0, 15)), 32'($urandom), acc);
    endtask

    task automatic check_all_zero();
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_instr", rsp_instr, 32'd0);
        check("rst_rsp_addr",  rsp_addr,  32'd0);
        check("rst_rsp_fault", rsp_fault, 2'd0);
        check("rst_ld_ready",  ld_ready,  1'b0);
        check("rst_init_done", init_done, 1'b0);
    endtask

    initial begin
        bit acc;
        model_reset();
        #2;
        check_all_zero();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Sweep with random traffic; loads and fetches must be ignored
        repeat (DEPTH + 4) rand_cycle();
        idle(1'b1);

        // Cleared memory, loads and fetches
        fetch(32'h3FC, 1'b1);
        load(8'd1, 32'h8C21_0001);
        fetch(32'h4, 1'b1);
        load(8'd7, 32'hFD01_2000);
        fetch(32'h1C, 1'b1);
        fetch(32'h6, 1'b1);
        fetch(32'h400, 1'b1);
        fetch(32'h402, 1'b1);
        idle(1'b1);

        // Back-pressure: three fetches with the consumer stalled
        cyc(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0, acc);
        repeat (3) cyc(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0, acc);
        fetch(32'h8, 1'b1);
        fetch(32'hC, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Load collides with fetch; the write must land
        cyc(1'b1, 32'h14, 1'b1, 1'b0, 1'b1, 8'd5, 32'hDEAD_BEEF, acc);
        check("collide_no_accept", acc, 1'b0);
        fetch(32'h14, 1'b1);
        idle(1'b1);

        // Flush while a response is held
        fetch(32'h4, 1'b0);
        cyc(1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 8'd0, 32'd0, acc);
        check("flush_no_accept", acc, 1'b0);
        idle(1'b0);

        repeat (1200) rand_cycle();

        // Reset with a response in flight
        idle(1'b1);
        load(8'd1, 32'h8C21_0001);
        fetch(32'h4, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all_zero();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (DEPTH) begin
            cyc($urandom_range(0, 1) == 1, rand_addr(), 1'b1, 1'b0,
                $urandom_range(0, 1) == 1, 8'd1, 32'($urandom), acc);
        end
        fetch(32'h4, 1'b1);
        idle(1'b1);
        repeat (200) rand_cycle();
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
